iccm_port_arbiter: RTL

Shares the single-port instruction memory (ICCM, 4096 x 32) between two requesters. One is the UART boot programmer's write stream from `iccm_controller`. The other is the TL-UL fetch read path from the ICCM `tlul_sram_adapter`. It buffers programmer writes in a small FIFO and arbitrates each cycle with bounded starvation of writes. It sits between those two blocks and `instr_mem_top`, and replaces the reset-muxed address select.

---
 rtl/iccm_port_arbiter_pkg.sv | 26 ++
 rtl/iccm_port_arbiter_wr_fifo.sv | 60 ++++++
 rtl/iccm_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/iccm_port_arbiter_pkg.sv
// Shared types and default sizing for the ICCM port arbiter.
// Struct fields use the default widths, so instance AW/DW must not exceed ICCM_AW/ICCM_DW.
package iccm_arb_pkg;

    localparam int unsigned ICCM_AW            = 12;
    localparam int unsigned ICCM_DW            = 32;
    localparam int unsigned ICCM_WR_FIFO_DEPTH = 4;
    localparam int unsigned ICCM_MAX_STALL     = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } iccm_grant_e;

    typedef struct packed {
        logic [ICCM_AW-1:0] addr;
        logic [ICCM_DW-1:0] data;
    } iccm_wr_t;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iccm_port_arbiter_wr_fifo.sv
// Synchronous FIFO buffering programmer writes; no bypass, head is registered storage.
module iccm_wr_fifo
    import iccm_arb_pkg::*;
#(
    parameter int unsigned Depth = ICCM_WR_FIFO_DEPTH,
    localparam int unsigned PW   = clog2_min1(Depth),
    localparam int unsigned CW   = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  iccm_wr_t      wdata_i,
    output iccm_wr_t      rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    iccm_wr_t        mem_q [Depth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full blocks push even when a pop frees a slot in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/iccm_port_arbiter.sv
// Single-port ICCM arbiter: buffered programmer writes vs. TL-UL fetch reads,
// reads preferred but a pending write wins after MaxStall consecutive read grants.
module iccm_port_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int unsigned AW          = ICCM_AW,
    parameter int unsigned DW          = ICCM_DW,
    parameter int unsigned WrFifoDepth = ICCM_WR_FIFO_DEPTH,
    parameter int unsigned MaxStall    = ICCM_MAX_STALL
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_req_i,
    output logic          rd_gnt_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_rvalid_o,
    output logic [DW-1:0] rd_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_wmask_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          wr_pending_o
);

    localparam int unsigned SW = clog2_min1(MaxStall + 1);
    localparam int unsigned CW = $clog2(WrFifoDepth + 1);

    iccm_wr_t      wr_entry;
    iccm_wr_t      head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push, pop;

    iccm_grant_e   grant;
    logic [SW-1:0] stall_q, stall_d;
    logic          rd_rvalid_q, rd_rvalid_d;

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = ICCM_AW'(wr_addr_i);
        wr_entry.data = ICCM_DW'(wr_data_i);
    end

    assign wr_ready_o   = ~fifo_full;
    assign wr_pending_o = (fifo_count != '0);
    assign push         = wr_valid_i & wr_ready_o;
    assign pop          = (grant == GNT_WR);

    iccm_wr_fifo #(
        .Depth (WrFifoDepth)
    ) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Grants are masked during reset so the memory port is quiet regardless of inputs.
    always_comb begin
        grant = GNT_NONE;
        if (!rst_i) begin
            if (!fifo_empty && (!rd_req_i || stall_q == SW'(MaxStall))) begin
                grant = GNT_WR;
            end else if (rd_req_i) begin
                grant = GNT_RD;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = 4'h0;
        rd_gnt_o    = 1'b0;
        unique case (grant)
            GNT_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = AW'(head.addr);
                mem_wdata_o = DW'(head.data);
                mem_wmask_o = 4'hF;
            end
            GNT_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rd_addr_i;
                rd_gnt_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // Stall counter tracks read grants a waiting write has already conceded.
    always_comb begin
        stall_d = stall_q;
        if (grant == GNT_WR || fifo_empty) begin
            stall_d = '0;
        end else if (grant == GNT_RD && stall_q != SW'(MaxStall)) begin
            stall_d = stall_q + SW'(1);
        end
        rd_rvalid_d = (grant == GNT_RD);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q     <= '0;
            rd_rvalid_q <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            rd_rvalid_q <= rd_rvalid_d;
        end
    end

    assign rd_rvalid_o = rd_rvalid_q;
    assign rd_rdata_o  = rd_rvalid_q ? mem_rdata_i : '0;

endmodule
